// File: rtl/event_decoder.sv
// Event decoder: 4-deep skid FIFO between the event router strobe and a
// valid/ready consumer. The head entry is unpacked into its fields, and the
// block flags bad packet types and FIFO overflow.
// The optional per-channel timestamp order check is enabled by defining
// EVENT_DECODER_TS_CHECK_EN.
module event_decoder #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4,
  parameter int CHIP_ID_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-2:0]         channel_event_in,
  input  logic                     load_event,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [1:0]               pkt_type,
  output logic [CHIP_ID_W-1:0]     chip_id,
  output logic [5:0]               channel_id,
  output logic [30:0]              timestamp,
  output logic                     first_packet,
  output logic [9:0]               adc_data,
  output logic [1:0]               trigger_type,
  output logic [2:0]               fifo_status,
  output logic                     bad_type,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     ts_order_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = WIDTH - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic          overflow_q, overflow_d;

  logic [PW-1:0] occ;
  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic [EW-1:0] head;

  // The extra pointer bit lets a full FIFO be told apart from an empty one.
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign full      = (occ == PW'(DEPTH));
  assign evt_valid = (occ != '0);
  assign rd_en     = evt_valid & evt_ready;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_en     = load_event & (~full | rd_en);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign occupancy    = occ;
  assign overflow     = overflow_q;
  assign pkt_type     = head[1:0];
  assign chip_id      = head[2 +: CHIP_ID_W];
  assign channel_id   = head[15:10];
  assign timestamp    = head[46:16];
  assign first_packet = head[47];
  assign adc_data     = head[57:48];
  assign trigger_type = head[59:58];
  assign fifo_status  = head[62:60];
  assign bad_type     = evt_valid & (head[1:0] != 2'b01);

  // Next-state for the pointers, the storage and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = channel_event_in;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (load_event & full & ~rd_en) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO state registers. Storage is cleared too, so the field outputs read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

`ifdef EVENT_DECODER_TS_CHECK_EN
  logic [30:0] ts_tab_q [64];
  logic [30:0] ts_tab_d [64];
  logic [63:0] ts_vld_q, ts_vld_d;
  logic        ts_err_q, ts_err_d;

  // Compare each consumed event against the last timestamp seen on its channel.
  always_comb begin
    ts_tab_d = ts_tab_q;
    ts_vld_d = ts_vld_q;
    ts_err_d = 1'b0;
    if (rd_en) begin
      if (~first_packet && ts_vld_q[channel_id] &&
          (timestamp < ts_tab_q[channel_id])) begin
        ts_err_d = 1'b1;
      end
      ts_tab_d[channel_id] = timestamp;
      ts_vld_d[channel_id] = 1'b1;
    end
  end

  // Timestamp table and the one-cycle error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_vld_q <= '0;
      ts_err_q <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        ts_tab_q[i] <= '0;
      end
    end else begin
      ts_tab_q <= ts_tab_d;
      ts_vld_q <= ts_vld_d;
      ts_err_q <= ts_err_d;
    end
  end

  assign ts_order_err = ts_err_q;
`else
  assign ts_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_event_decoder.sv
// Scoreboard bench for event_decoder: stimulus pushes expected events into
// a queue, and a negedge monitor pops and checks every accepted head entry.
module tb_event_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [62:0] channel_event_in;
  logic        load_event;
  logic        evt_ready;
  logic        evt_valid;
  logic [1:0]  pkt_type;
  logic [7:0]  chip_id;
  logic [5:0]  channel_id;
  logic [30:0] timestamp;
  logic        first_packet;
  logic [9:0]  adc_data;
  logic [1:0]  trigger_type;
  logic [2:0]  fifo_status;
  logic        bad_type;
  logic        overflow;
  logic [2:0]  occupancy;
  logic        ts_order_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ts_err_cnt = 0;
  logic [62:0] exp_q [$];

  event_decoder dut (
    .clk              (clk),
    .reset            (reset),
    .channel_event_in (channel_event_in),
    .load_event       (load_event),
    .evt_ready        (evt_ready),
    .evt_valid        (evt_valid),
    .pkt_type         (pkt_type),
    .chip_id          (chip_id),
    .channel_id       (channel_id),
    .timestamp        (timestamp),
    .first_packet     (first_packet),
    .adc_data         (adc_data),
    .trigger_type     (trigger_type),
    .fifo_status      (fifo_status),
    .bad_type         (bad_type),
    .overflow         (overflow),
    .occupancy        (occupancy),
    .ts_order_err     (ts_order_err)
  );

  always #5 clk = ~clk;

  function automatic logic [62:0] mk(
    input logic [1:0]  pt,
    input logic [7:0]  chip,
    input logic [5:0]  ch,
    input logic [30:0] ts,
    input logic        fp,
    input logic [9:0]  adc,
    input logic [1:0]  tr,
    input logic [2:0]  fs
  );
    return {fs, tr, adc, fp, ts, ch, chip, pt};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      logic [62:0] e;
      logic [62:0] got;
      got = {fifo_status, trigger_type, adc_data, first_packet,
             timestamp, channel_id, chip_id, pkt_type};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected none", got);
      end else begin
        e = exp_q.pop_front();
        chk("sb_fields", {1'b0, got}, {1'b0, e});
        chk("sb_bad_type", {63'd0, bad_type}, {63'd0, e[1:0] != 2'b01});
      end
    end
    if (!reset && ts_order_err) ts_err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [62:0] ev, input bit accept);
    channel_event_in = ev;
    load_event = 1'b1;
    if (accept) exp_q.push_back(ev);
    tick();
    load_event = 1'b0;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (occupancy == 3'd0) break;
      tick();
    end
    chk("drain_occ", {61'd0, occupancy}, 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  logic [62:0] ev [5];
  int base;
  int exp_ts;

  initial begin
    reset = 1'b1;
    channel_event_in = '0;
    load_event = 1'b0;
    evt_ready = 1'b0;
    tick();
    chk("rst_valid", {63'd0, evt_valid}, 64'd0);
    chk("rst_occ", {61'd0, occupancy}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_tserr", {63'd0, ts_order_err}, 64'd0);
    chk("rst_ts", {33'd0, timestamp}, 64'd0);
    chk("rst_chip", {56'd0, chip_id}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single event, one-cycle latency, exact field decode.
    evt_ready = 1'b1;
    strobe(mk(2'b01, 8'h1A, 6'd0, 31'd100, 1'b0, 10'd733, 2'b00, 3'b101), 1);
    chk("t1_valid", {63'd0, evt_valid}, 64'd1);
    chk("t1_occ", {61'd0, occupancy}, 64'd1);
    chk("t1_chip", {56'd0, chip_id}, 64'h1A);
    chk("t1_ts", {33'd0, timestamp}, 64'd100);
    chk("t1_adc", {54'd0, adc_data}, 64'd733);
    chk("t1_trig", {62'd0, trigger_type}, 64'd0);
    tick();
    chk("t1_occ_after", {61'd0, occupancy}, 64'd0);
    chk("t1_valid_after", {63'd0, evt_valid}, 64'd0);

    // Five strobes with no consumer: fifth is dropped, overflow set.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      ev[i] = mk(2'b01, 8'h20 + 8'(i), 6'(i + 1), 31'd1000 + 31'(i),
                 1'b0, 10'(i * 3), 2'(i), 3'(i));
    for (int i = 0; i < 5; i++) strobe(ev[i], i < 4);
    chk("t2_occ", {61'd0, occupancy}, 64'd4);
    chk("t2_ovf", {63'd0, overflow}, 64'd1);
    chk("t2_head_ts", {33'd0, timestamp}, 64'd1000);
    tick();
    chk("t2_head_stable", {33'd0, timestamp}, 64'd1000);
    drain();
    chk("t2_ovf_sticky", {63'd0, overflow}, 64'd1);
    do_reset();
    chk("t2_ovf_rst", {63'd0, overflow}, 64'd0);

    // Full FIFO, simultaneous write and read.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(ev[i], 1);
    chk("t3_occ_full", {61'd0, occupancy}, 64'd4);
    evt_ready = 1'b1;
    strobe(ev[4], 1);
    chk("t3_occ_same", {61'd0, occupancy}, 64'd4);
    chk("t3_ovf", {63'd0, overflow}, 64'd0);
    drain();

    // Non-data packet type flagged, following data event clean.
    evt_ready = 1'b0;
    strobe(mk(2'b10, 8'h33, 6'd9, 31'd77, 1'b0, 10'd5, 2'b01, 3'b000), 1);
    chk("t4_valid", {63'd0, evt_valid}, 64'd1);
    chk("t4_bad", {63'd0, bad_type}, 64'd1);
    strobe(mk(2'b01, 8'h34, 6'd9, 31'd78, 1'b0, 10'd6, 2'b10, 3'b010), 1);
    drain();
    chk("t4_bad_idle", {63'd0, bad_type}, 64'd0);

    // Reset with three entries queued after an overflow.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(ev[i], i < 4);
    chk("t5_ovf_pre", {63'd0, overflow}, 64'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t5_occ3", {61'd0, occupancy}, 64'd3);
    reset = 1'b1;
    #1;
    chk("t5_valid", {63'd0, evt_valid}, 64'd0);
    chk("t5_occ", {61'd0, occupancy}, 64'd0);
    chk("t5_ovf", {63'd0, overflow}, 64'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();

    // Timestamp ordering per channel.
    base = ts_err_cnt;
    evt_ready = 1'b1;
    strobe(mk(2'b01, 8'h01, 6'd5, 31'd200, 1'b0, 10'd1, 2'b00, 3'b000), 1);
    strobe(mk(2'b01, 8'h01, 6'd5, 31'd150, 1'b0, 10'd2, 2'b00, 3'b000), 1);
    strobe(mk(2'b01, 8'h01, 6'd6, 31'd150, 1'b0, 10'd3, 2'b00, 3'b000), 1);
    drain();
    tick();
    tick();
`ifdef EVENT_DECODER_TS_CHECK_EN
    exp_ts = 1;
`else
    exp_ts = 0;
`endif
    chk("t6_ts_err_cnt", 64'(ts_err_cnt - base), 64'(exp_ts));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
